// File: rtl/burst_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : burst_mem_responder_pkg
//  Description : Shared constants and FSM state type for the 4-beat, 64-bit
//                burst memory responder and its line RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package burst_mem_responder_pkg;

    localparam int BURST_BEATS = 4;
    localparam int BEAT_WIDTH  = 64;
    localparam int LINE_WIDTH  = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } burst_state_t;

endpackage
`default_nettype wire

// File: rtl/burst_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : burst_line_ram
//  Description : Line-organized backing store, 2^LINE_ADDR_BITS x 256 bits.
//                One combinational read port and one synchronous full-line
//                write port. Contents are never reset.
//  Ports       : clk      - rising-edge clock
//                i_raddr  - read line index
//                o_rdata  - read line data (combinational)
//                i_we     - full-line write enable
//                i_waddr  - write line index
//                i_wdata  - write line data
//  Revision    : 1.0 - initial release
// ============================================================================
module burst_line_ram
    import burst_mem_responder_pkg::*;
#(
    parameter int LINE_ADDR_BITS = 10
) (
    input  logic                      clk,
    input  logic [LINE_ADDR_BITS-1:0] i_raddr,
    output logic [LINE_WIDTH-1:0]     o_rdata,
    input  logic                      i_we,
    input  logic [LINE_ADDR_BITS-1:0] i_waddr,
    input  logic [LINE_WIDTH-1:0]     i_wdata
);

    logic [LINE_WIDTH-1:0] r_mem [0:(1<<LINE_ADDR_BITS)-1];

    assign o_rdata = r_mem[i_raddr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/burst_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : burst_mem_responder
//  Description : Memory-side responder for the 64-bit, 4-beat burst protocol.
//                Accepts a read or write burst in IDLE, waits LATENCY cycles,
//                then strobes bmem_resp for 4 beats. Writes are collected in
//                a line buffer and committed atomically on the last beat.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                bmem_address  - burst byte address (bits [4:0] ignored)
//                bmem_read     - read burst request
//                bmem_write    - write burst request
//                bmem_wdata    - write beat data
//                bmem_rdata    - read beat data (zero unless read beat)
//                bmem_resp     - beat strobe, 4 consecutive cycles per burst
//                proto_err     - sticky: read and write high at acceptance
//  Revision    : 1.0 - initial release
// ============================================================================
module burst_mem_responder
    import burst_mem_responder_pkg::*;
#(
    parameter int LINE_ADDR_BITS = 10,
    parameter int LATENCY        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           bmem_address,
    input  logic                  bmem_read,
    input  logic                  bmem_write,
    input  logic [BEAT_WIDTH-1:0] bmem_wdata,
    output logic [BEAT_WIDTH-1:0] bmem_rdata,
    output logic                  bmem_resp,
    output logic                  proto_err
);

    // Counter reload value; unused when LATENCY is 0 since WAIT is skipped.
    localparam logic [7:0] c_lat_load = (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);

    burst_state_t              r_state;
    logic [LINE_ADDR_BITS-1:0] r_idx;
    logic                      r_is_read;
    logic [7:0]                r_lat_cnt;
    logic [1:0]                r_beat;
    logic [LINE_WIDTH-1:0]     r_line;
    logic                      r_proto_err;

    logic [LINE_ADDR_BITS-1:0] w_req_idx;
    logic [LINE_WIDTH-1:0]     w_ram_rdata;
    logic [LINE_WIDTH-1:0]     w_commit_line;
    logic                      w_commit;
    logic [BEAT_WIDTH-1:0]     w_beats [BURST_BEATS];
    logic                      w_unused_addr;

    assign w_req_idx     = bmem_address[LINE_ADDR_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign w_unused_addr = ^{bmem_address[31:LINE_ADDR_BITS+OFFSET_BITS],
                             bmem_address[OFFSET_BITS-1:0]};

    // Split the line buffer into beats for the read mux.
    for (genvar g = 0; g < BURST_BEATS; g++) begin : g_beat
        assign w_beats[g] = r_line[g*BEAT_WIDTH +: BEAT_WIDTH];
    end

    // The final beat is still on bmem_wdata when the commit happens, so the
    // committed line splices it onto the three beats already buffered.
    assign w_commit_line = {bmem_wdata, r_line[LINE_WIDTH-BEAT_WIDTH-1:0]};
    // Gated by rst so a reset on the last beat leaves the array untouched.
    assign w_commit      = (r_state == BURST) && !r_is_read && (r_beat == 2'd3) && !rst;

    burst_line_ram #(
        .LINE_ADDR_BITS (LINE_ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .i_raddr (w_req_idx),
        .o_rdata (w_ram_rdata),
        .i_we    (w_commit),
        .i_waddr (r_idx),
        .i_wdata (w_commit_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_is_read   <= 1'b0;
            r_lat_cnt   <= 8'd0;
            r_beat      <= 2'd0;
            r_line      <= '0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bmem_read || bmem_write) begin
                        r_idx     <= w_req_idx;
                        r_is_read <= bmem_read;
                        r_lat_cnt <= c_lat_load;
                        r_beat    <= 2'd0;
                        if (bmem_read) begin
                            r_line <= w_ram_rdata;
                        end
                        if (bmem_read && bmem_write) begin
                            r_proto_err <= 1'b1;
                        end
                        r_state <= (LATENCY == 0) ? BURST : WAIT;
                    end
                end
                WAIT: begin
                    if (r_lat_cnt == 8'd0) begin
                        r_state <= BURST;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 8'd1;
                    end
                end
                BURST: begin
                    if (!r_is_read) begin
                        r_line[r_beat*BEAT_WIDTH +: BEAT_WIDTH] <= bmem_wdata;
                    end
                    r_beat <= r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Initiator drops its request here; anything seen is ignored.
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bmem_resp  = (r_state == BURST);
    assign bmem_rdata = ((r_state == BURST) && r_is_read) ? w_beats[r_beat] : '0;
    assign proto_err  = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_burst_mem_responder
//  Description : Self-checking bench for burst_mem_responder. A driver issues
//                bursts and pushes expected beats into a queue; a monitor
//                pops and compares on every resp beat. A second instance with
//                LATENCY=0 covers the zero-latency path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_mem_responder;

    localparam int LAT = 8;
    localparam int LAB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bmem_address;
    logic        bmem_read, bmem_write;
    logic [63:0] bmem_wdata, bmem_rdata;
    logic        bmem_resp, proto_err;

    logic [31:0] z_address;
    logic        z_read, z_write;
    logic [63:0] z_wdata, z_rdata;
    logic        z_resp, z_perr;

    always #5 clk = ~clk;

    burst_mem_responder #(.LINE_ADDR_BITS(LAB), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bmem_address(bmem_address), .bmem_read(bmem_read),
        .bmem_write(bmem_write), .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata),
        .bmem_resp(bmem_resp), .proto_err(proto_err)
    );

    burst_mem_responder #(.LINE_ADDR_BITS(LAB), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .bmem_address(z_address), .bmem_read(z_read),
        .bmem_write(z_write), .bmem_wdata(z_wdata), .bmem_rdata(z_rdata),
        .bmem_resp(z_resp), .proto_err(z_perr)
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    bit           mon_en  = 1'b0;
    logic [63:0]  exp_q [$];
    logic [255:0] model [int];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr >> 5) & 32'h3FF);
    endfunction

    // Monitor: every beat must match the queued expectation; outside beats
    // rdata must be zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bmem_resp) begin
                if (exp_q.size() == 0) check("unexpected_resp", 64'd1, 64'd0);
                else                   check("rdata_beat", bmem_rdata, exp_q.pop_front());
            end else begin
                check("rdata_zero_when_idle", bmem_rdata, 64'd0);
            end
        end
    end

    // One burst on the LATENCY=8 instance. b2b means the previous burst left
    // us at its DONE negedge, so the request is presented during DONE and
    // must only be accepted one cycle later.
    task automatic burst(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wline, input bit b2b, input bit keep);
        int idx, n, exp_first;
        idx = line_of(addr);
        if (!b2b) @(negedge clk);
        bmem_address = addr;
        bmem_read    = rd;
        bmem_write   = wr;
        bmem_wdata   = wline[63:0];
        for (int k = 0; k < 4; k++) exp_q.push_back(rd ? model[idx][64*k +: 64] : 64'd0);
        exp_first = b2b ? LAT + 2 : LAT + 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bmem_resp && n < exp_first + 20);
        check("first_resp_latency", 64'(n), 64'(exp_first));
        if (!bmem_resp) begin
            exp_q.delete();
            bmem_read  = 1'b0;
            bmem_write = 1'b0;
            return;
        end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("resp_held_high", 64'(bmem_resp), 64'd1);
            bmem_wdata = wline[64*k +: 64];
        end
        @(negedge clk);
        check("resp_low_after_burst", 64'(bmem_resp), 64'd0);
        if (wr && !rd) model[idx] = wline;
        if (!keep) begin
            bmem_read  = 1'b0;
            bmem_write = 1'b0;
        end
    endtask

    logic [255:0] line_a;
    logic [255:0] tmp;
    int           lines [8] = '{'h20, 'h0, 'h3FF, 'h155, 'h82, 'h2AA, 'h7, 'h100};

    initial begin
        int n;
        bit prev_keep, keep, rd;
        logic [31:0] addr;

        bmem_address = '0; bmem_read = 1'b0; bmem_write = 1'b0; bmem_wdata = '0;
        z_address    = '0; z_read    = 1'b0; z_write    = 1'b0; z_wdata    = '0;
        line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_resp", 64'(bmem_resp), 64'd0);
        check("reset_rdata", bmem_rdata, 64'd0);
        check("reset_proto_err", 64'(proto_err), 64'd0);
        check("reset_resp_lat0", 64'(z_resp), 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Write then read, offset bits ignored, high-bit aliasing.
        burst(1'b0, 1'b1, 32'h0000_1040, line_a, 1'b0, 1'b0);
        burst(1'b1, 1'b0, 32'h0000_1040, '0, 1'b0, 1'b0);
        burst(1'b1, 1'b0, 32'h0000_105F, '0, 1'b0, 1'b0);
        burst(1'b1, 1'b0, 32'h0000_9040, '0, 1'b0, 1'b0);

        // Preload the working set so random reads have known contents.
        for (int i = 0; i < 8; i++) begin
            burst(1'b0, 1'b1, 32'(lines[i]) << 5, rand_line(), 1'b0, 1'b0);
        end

        // Random traffic with occasional back-to-back requests raised in DONE.
        prev_keep = 1'b0;
        for (int it = 0; it < 40; it++) begin
            rd   = 1'($urandom_range(0, 1));
            addr = ($urandom & 32'hFFFF_801F) | (32'(lines[$urandom_range(0, 7)]) << 5);
            keep = (it != 39) && ($urandom_range(0, 2) == 0);
            burst(rd, !rd, addr, rand_line(), prev_keep, keep);
            prev_keep = keep;
        end
        check("proto_err_clear_before", 64'(proto_err), 64'd0);

        // Read and write together: read wins and the flag sticks.
        burst(1'b1, 1'b1, 32'(lines[3]) << 5, rand_line(), 1'b0, 1'b0);
        check("proto_err_set", 64'(proto_err), 64'd1);
        burst(1'b0, 1'b1, 32'(lines[3]) << 5, rand_line(), 1'b0, 1'b0);
        burst(1'b1, 1'b0, 32'(lines[3]) << 5, '0, 1'b0, 1'b0);
        check("proto_err_sticky", 64'(proto_err), 64'd1);

        // Reset during beat 2 of a write to line 0x20: no commit.
        @(negedge clk);
        tmp = rand_line();
        bmem_address = 32'h20 << 5; bmem_write = 1'b1; bmem_wdata = tmp[63:0];
        for (int k = 0; k < 4; k++) exp_q.push_back(64'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bmem_resp && n < LAT + 20);
        check("rstwr_first_resp", 64'(n), 64'(LAT + 1));
        @(negedge clk); bmem_wdata = tmp[127:64];
        @(negedge clk); bmem_wdata = tmp[191:128];
        rst = 1'b1; bmem_write = 1'b0;
        @(negedge clk);
        check("rstwr_resp_dropped", 64'(bmem_resp), 64'd0);
        check("rstwr_proto_err_cleared", 64'(proto_err), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        burst(1'b1, 1'b0, 32'h20 << 5, '0, 1'b0, 1'b0);

        // Zero-latency instance: write then read line 2.
        for (int op = 0; op < 2; op++) begin
            @(negedge clk);
            z_address = 32'h40; z_write = (op == 0); z_read = (op == 1); z_wdata = line_a[63:0];
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!z_resp && n < 20);
            check("lat0_first_resp", 64'(n), 64'd1);
            for (int k = 0; k < 4; k++) begin
                if (k > 0) @(negedge clk);
                z_wdata = line_a[64*k +: 64];
                check("lat0_resp_high", 64'(z_resp), 64'd1);
                check("lat0_rdata", z_rdata, (op == 1) ? line_a[64*k +: 64] : 64'd0);
            end
            @(negedge clk);
            check("lat0_resp_low", 64'(z_resp), 64'd0);
            z_read = 1'b0; z_write = 1'b0;
        end

        repeat (2) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
Synthesizable responder for the 64-bit, 4-beat burst memory protocol that the cacheline adaptor initiates on bmem_*.
- Holds a line-organized backing store of 256-bit lines and answers read and write bursts after a programmable latency.
- Sits at the memory end of the chain: caches -> arbiter -> cacheline adaptor -> this block.
- Used as the on-chip main-memory model for integration runs and FPGA bring-up.

Parameters:
LINE_ADDR_BITS, 10, log2 of the number of 256-bit lines stored (depth 1024 lines = 32 KiB).
LATENCY, 8, idle cycles between request acceptance and the first resp beat (legal range 0..255).

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  synchronous, active-high reset.
bmem_address  input  32  byte address of the burst; bits [4:0] are ignored.
bmem_read  input  1  read burst request; held by the initiator until the 4th resp beat.
bmem_write  input  1  write burst request; held by the initiator until the 4th resp beat.
bmem_wdata  input  64  write beat data; initiator presents beat k during the k-th resp cycle.
bmem_rdata  output  64  read beat data; valid only while bmem_resp=1.
bmem_resp  output  1  beat strobe; high for exactly 4 consecutive cycles per burst.
proto_err  output  1  sticky flag: read and write were seen high together at acceptance.

Behaviour:
- Reset values: bmem_resp=0, bmem_rdata=0, proto_err=0, state=IDLE, counters=0. The storage array is not cleared by rst.
- Line index = bmem_address[LINE_ADDR_BITS+4:5]. Higher address bits are ignored, so addresses wrap modulo the depth.
- FSM states: IDLE, WAIT, BURST, DONE.
- IDLE:
  - If read|write is high, latch the line index and op (read wins if both are high; proto_err<=1).
  - For a read, also latch the array line into a 256-bit line buffer.
  - Next state is WAIT if LATENCY>0, else BURST. Latency counter loads LATENCY-1.
- WAIT: decrement the counter each cycle; at 0, go to BURST. bmem_resp stays 0.
- BURST:
  - bmem_resp=1 and beat counter k=0..3 (2-bit), incrementing each cycle.
  - Read: bmem_rdata = buffer[64k+63:64k], driven combinationally from k.
  - Write: on each edge, buffer[64k+63:64k] <= bmem_wdata.
  - After k=3, go to DONE. On that transition a write commits the full buffer to the array in one write.
- DONE: bmem_resp=0 for one cycle and requests are ignored (the initiator drops its request here); then go to IDLE.
- Timing: a request first high in cycle 0 while in IDLE gives resp in cycles LATENCY+1 through LATENCY+4. The next request can be accepted in cycle LATENCY+6.
- bmem_rdata=0 whenever bmem_resp=0, or when the op is a write.
- Once accepted, the address and op are fixed for the burst. Dropping the request mid-burst does not abort it; all 4 beats complete.
- A write is atomic: the array is updated only at the end of the burst. A reset during WAIT or BURST returns to IDLE with resp=0 on the next cycle and leaves the array unchanged.
- Read-after-write to the same line sees the new data, because the commit happens before DONE/IDLE acceptance.
- proto_err clears only on rst.

Decomposition:
- Shared package (rv32i_types or a mem package):
  - BURST_BEATS=4, BEAT_WIDTH=64, LINE_WIDTH=256, OFFSET_BITS=5.
  - typedef enum burst_state_t {IDLE, WAIT, BURST, DONE}.
- One sub-module, burst_line_ram: 2^LINE_ADDR_BITS x 256-bit, one combinational-read port, one synchronous full-line write port; no reset on contents.

Test Plan:
- Write then read: write burst to 0x0000_1040 with beats 0x1111..., 0x2222..., 0x3333..., 0x4444...; then read the same address -> resp high in cycles LATENCY+1..+4, rdata returns the same 4 beats in order.
- Latency: LATENCY=0 and LATENCY=8 -> first resp exactly 1 and 9 cycles after request assertion; resp high for exactly 4 cycles, then low for at least 1 cycle.
- Address handling: read 0x0000_105F (offset bits set) -> same data as 0x0000_1040. With LINE_ADDR_BITS=10, address 0x0000_9040 aliases to 0x0000_1040.
- Protocol error: read=write=1 at acceptance -> read burst performed, proto_err=1 and stays 1 until rst.
- Reset mid-write: rst asserted during beat 2 of a write to line 0x20 -> resp=0 next cycle; a later read of line 0x20 returns the old contents.
- Back-to-back requests: request re-asserted in DONE -> ignored; accepted in the following IDLE cycle; the second burst's data is correct.
